// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Shares one reg_file between NUM_REQ requesters. One winner per access:
//   it gets a 1-cycle o_gnt while the reg_file enables are high, and a read
//   returns o_rvalid (one-hot) one cycle later with o_rdata from the reg_file.
//
//   Build option: define RF_ARB_FIXED_PRIO_EN for fixed priority (lowest index
//   wins); otherwise round-robin starting after the previous winner.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req / i_req_we          per-requester request level / 1 = write
//   i_req_addr, i_req_wdata   packed per-requester address / write data
//   o_gnt, o_rvalid           one-hot 1-cycle grant / read-data-valid pulses
//   o_rdata                   read data, straight from i_rf_read_data
//   o_rf_*                    to reg_file i_* ports
//   i_rf_read_data            from reg_file o_read_data (registered there)
//
// state   | meaning
// IDLE    | arbitrate; a grant loads the reg_file op and raises o_gnt
// ACCESS  | reg_file performs the op on the closing edge
// RD_RESP | reg_file read data valid; o_rvalid to the winner

module reg_file_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ-1:0]               i_req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]               o_gnt,
  output logic [NUM_REQ-1:0]               o_rvalid,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_rf_write_enable,
  output logic                             o_rf_read_enable,
  output logic [ADDRESS_WIDTH-1:0]         o_rf_address,
  output logic [DATA_WIDTH-1:0]            o_rf_write_data,
  input  logic [DATA_WIDTH-1:0]            i_rf_read_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_REQ-1:0]         win_q, win_d;
  logic                       op_we_q, op_we_d;
  logic [NUM_REQ-1:0]         gnt_d, rvalid_d;
  logic                       we_d, re_d;
  logic [ADDRESS_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]      wdata_d;

  logic [NUM_REQ-1:0]         req_pick, arb_oh;
  logic                       sel_we;
  logic [ADDRESS_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]      sel_wdata;

`ifndef RF_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]           last_q, last_d, arb_idx;
  logic [NUM_REQ-1:0]         req_hi;
`endif

  assign o_rdata = i_rf_read_data;

  // Round-robin: requests above the last winner take precedence; if there are
  // none, the search wraps to the full request vector. Both cases then pick
  // the lowest set index, which gives the last+1 .. wrap order.
  always_comb begin
`ifdef RF_ARB_FIXED_PRIO_EN
    req_pick = i_req;
`else
    req_hi = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_hi[k] = i_req[k] && (IDX_W'(k) > last_q);
    end
    req_pick = (|req_hi) ? req_hi : i_req;
    arb_idx  = last_q;
`endif
    arb_oh = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_pick[k]) begin
        arb_oh    = '0;
        arb_oh[k] = 1'b1;
`ifndef RF_ARB_FIXED_PRIO_EN
        arb_idx   = IDX_W'(k);
`endif
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_oh[k]) begin
        sel_we    = i_req_we[k];
        sel_addr  = i_req_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_wdata = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    op_we_d  = op_we_q;
    gnt_d    = '0;
    rvalid_d = '0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = o_rf_address;
    wdata_d  = o_rf_write_data;
`ifndef RF_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          win_d   = arb_oh;
          op_we_d = sel_we;
          gnt_d   = arb_oh;
          we_d    = sel_we;
          re_d    = !sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
`ifndef RF_ARB_FIXED_PRIO_EN
          last_d  = arb_idx;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_we_q) begin
          state_d = IDLE;
        end else begin
          rvalid_d = win_q;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= IDLE;
      win_q             <= '0;
      op_we_q           <= 1'b0;
      o_gnt             <= '0;
      o_rvalid          <= '0;
      o_rf_write_enable <= 1'b0;
      o_rf_read_enable  <= 1'b0;
      o_rf_address      <= '0;
      o_rf_write_data   <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q            <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q           <= state_d;
      win_q             <= win_d;
      op_we_q           <= op_we_d;
      o_gnt             <= gnt_d;
      o_rvalid          <= rvalid_d;
      o_rf_write_enable <= we_d;
      o_rf_read_enable  <= re_d;
      o_rf_address      <= addr_d;
      o_rf_write_data   <= wdata_d;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q            <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    o_gnt, o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic            rf_we, rf_re;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_wdata;
  logic [DW-1:0]   rf_rdata;
  logic [DW-1:0]   rf_mem [16];

  always #5 clk = ~clk;

  reg_file_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_rf_write_enable(rf_we), .o_rf_read_enable(rf_re),
    .o_rf_address(rf_addr), .o_rf_write_data(rf_wdata),
    .i_rf_read_data(rf_rdata)
  );

  // reg_file stand-in: registered read, write on enable, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_rdata <= '0;
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
      if (rf_re) rf_rdata <= rf_mem[rf_addr];
    end
  end

  // ---------------- transaction-level reference ----------------
  int            m_busy, m_last, m_win, m_w;
  bit            m_read_pend;
  logic [N-1:0]  m_gnt, m_rvalid;
  logic          m_we, m_re;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] shadow [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_last = N - 1; m_win = 0; m_read_pend = 0;
      m_gnt = '0; m_rvalid = '0; m_we = 0; m_re = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int i = 0; i < 16; i++) shadow[i] = '0;
    end else begin
      m_gnt = '0; m_rvalid = '0; m_we = 0; m_re = 0;
      if (m_busy > 0) begin
        if (m_read_pend && m_busy == 2) m_rvalid[m_win] = 1'b1;
        m_busy--;
      end else if (req != '0) begin
        m_w = 0;
`ifdef RF_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (req[i]) m_w = i;
`else
        for (int i = N; i >= 1; i--) if (req[(m_last + i) % N]) m_w = (m_last + i) % N;
        m_last = m_w;
`endif
        m_win = m_w;
        m_gnt[m_w] = 1'b1;
        m_addr  = req_addr[m_w*AW +: AW];
        m_wdata = req_wdata[m_w*DW +: DW];
        if (req_we[m_w]) begin
          m_we = 1; shadow[m_addr] = m_wdata; m_busy = 1; m_read_pend = 0;
        end else begin
          m_re = 1; m_rdata = shadow[m_addr]; m_busy = 2; m_read_pend = 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  int gnt_log [$];
  logic [DW-1:0] rd_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt",      32'(o_gnt),    32'(m_gnt));
      chk("rvalid",   32'(o_rvalid), 32'(m_rvalid));
      chk("rf_we",    32'(rf_we),    32'(m_we));
      chk("rf_re",    32'(rf_re),    32'(m_re));
      chk("rf_addr",  32'(rf_addr),  32'(m_addr));
      chk("rf_wdata", rf_wdata,      m_wdata);
      chk("en_excl",  32'(rf_we & rf_re), 32'd0);
      if (m_rvalid != '0) chk("rdata", o_rdata, m_rdata);
      for (int k = 0; k < N; k++) if (o_gnt[k]) gnt_log.push_back(k);
      if (o_rvalid != '0) rd_log.push_back(o_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1;
    req_we[k] = we;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    gnt_log.delete();
    rd_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int exp_order [5];

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt",    32'(o_gnt), 32'd0);
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_we",     32'(rf_we), 32'd0);
    chk("rst_re",     32'(rf_re), 32'd0);
    chk("rst_addr",   32'(rf_addr), 32'd0);
    chk("rst_wdata",  rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single write then read of addr 3
    set_req(0, 1'b1, 4'd3, 32'hDEADBEEF);
    tick(); req[0] = 1'b0;
    @(negedge clk);
    chk("wr_gnt",  32'(o_gnt), 32'h1);
    chk("wr_we",   32'(rf_we), 32'd1);
    chk("wr_re",   32'(rf_re), 32'd0);
    chk("wr_addr", 32'(rf_addr), 32'd3);
    @(negedge clk);
    chk("wr_we_drop",  32'(rf_we), 32'd0);
    chk("wr_gnt_drop", 32'(o_gnt), 32'd0);
    tick();
    set_req(0, 1'b0, 4'd3, 32'd0);
    tick(); req[0] = 1'b0;
    @(negedge clk);
    chk("rd_gnt", 32'(o_gnt), 32'h1);
    chk("rd_re",  32'(rf_re), 32'd1);
    @(negedge clk);
    chk("rd_rvalid", 32'(o_rvalid), 32'h1);
    chk("rd_rdata",  o_rdata, 32'hDEADBEEF);
    tick();

    // all four hold reads: grant order
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k + 4), 32'd0);
    repeat (13) @(posedge clk);
    #2 req = '0;
    repeat (4) tick();
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("rr_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) chk("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));

    // simultaneous write (req1) and read (req2) of addr 5
    do_reset();
    set_req(1, 1'b1, 4'd5, 32'h12345678);
    set_req(2, 1'b0, 4'd5, 32'd0);
    tick(); req[1] = 1'b0;
    tick();
    tick(); req[2] = 1'b0;
    repeat (3) tick();
    chk("mix_gcount", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() >= 2) begin
      chk("mix_first",  32'(gnt_log[0]), 32'd1);
      chk("mix_second", 32'(gnt_log[1]), 32'd2);
    end
    chk("mix_rcount", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() >= 1) chk("mix_rdata", rd_log[0], 32'h12345678);

    // request fields change after being latched
    do_reset();
    set_req(3, 1'b0, 4'd7, 32'd0);
    tick();
    req_addr[3*AW +: AW] = 4'd9;
    req[3] = 1'b0;
    @(negedge clk);
    chk("latch_gnt",  32'(o_gnt), 32'h8);
    chk("latch_addr", 32'(rf_addr), 32'd7);
    @(negedge clk);
    chk("latch_rvalid", 32'(o_rvalid), 32'h8);
    chk("latch_addr2",  32'(rf_addr), 32'd7);
    tick();

    // reset during RD_RESP
    do_reset();
    set_req(0, 1'b0, 4'd3, 32'd0);
    tick(); req = '0;
    tick();
    chk("mid_rvalid_pre", 32'(o_rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid", 32'(o_rvalid), 32'd0);
    chk("mid_gnt",    32'(o_gnt), 32'd0);
    chk("mid_we",     32'(rf_we), 32'd0);
    chk("mid_re",     32'(rf_re), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), 32'd0);
    tick(); req = '0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(o_gnt), 32'h1);
    repeat (3) tick();

    // idle
    req = '0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_gnt",    32'(o_gnt), 32'd0);
      chk("idle_rvalid", 32'(o_rvalid), 32'd0);
      chk("idle_we",     32'(rf_we), 32'd0);
      chk("idle_re",     32'(rf_re), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
